// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline MEM stage.
package mips_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned REG_IDX_W       = 5;
  localparam int unsigned TIMEOUT_DEFAULT = 16;

  // Memory-access handshake state.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  // MEM/WB pipeline register payload.
  typedef struct packed {
    logic                 reg_write;
    logic                 mem_to_reg;
    logic [XLEN-1:0]      alu_out;
    logic [XLEN-1:0]      read_data;
    logic [REG_IDX_W-1:0] write_reg;
  } mem_wb_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: loads every cycle, or inserts a bubble by
// clearing the control bits while holding the data fields.
module mem_wb_reg
  import mips_pkg::*;
(
  input  logic    i_clk,
  input  logic    i_reset,
  input  logic    i_bubble,
  input  logic    i_load_rdata,
  input  mem_wb_t i_d,
  output mem_wb_t o_q
);

  mem_wb_t r_q;

  // Register update: reset, bubble, or load (read data only on load completion).
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_q <= '0;
    end else if (i_bubble) begin
      r_q.reg_write  <= 1'b0;
      r_q.mem_to_reg <= 1'b0;
    end else begin
      r_q.reg_write  <= i_d.reg_write;
      r_q.mem_to_reg <= i_d.mem_to_reg;
      r_q.alu_out    <= i_d.alu_out;
      r_q.write_reg  <= i_d.write_reg;
      if (i_load_rdata) begin
        r_q.read_data <= i_d.read_data;
      end
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage controller: data-memory request/ack handshake with timeout,
// pipeline stall generation and the MEM/WB register.
module mem_access_stage
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
  parameter int unsigned CW      = 5
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        RegWriteM,
  input  logic        MemtoRegM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] WriteRegM,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  input  logic [31:0] MemRData,
  input  logic        MemAck,
  output logic        StallM,
  output logic        MemErr,
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic [31:0] ALUOutW,
  output logic [31:0] ReadDataW,
  output logic [31:0] WriteRegW
);

  mem_state_e    r_state;
  mem_state_e    w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_mem_err;
  logic          w_access;
  logic          w_req;
  logic          w_abort;
  logic          w_stall;
  logic          w_complete;
  mem_wb_t       w_wb_d;
  mem_wb_t       w_wb_q;
  logic          w_unused_wreg;

  assign w_access = MemtoRegM | MemWriteM;

  // State, timeout counter and error pulse registers.
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_mem_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_mem_err <= w_abort;
    end
  end

  // Next state, counter and request/abort decode; reset suppresses the request.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_req       = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_req = w_access;
        if (w_access && !MemAck) begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = CW'(1);
        end
      end
      ST_WAIT: begin
        w_req = 1'b1;
        if (MemAck) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CW'(TIMEOUT)) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
    if (Reset) begin
      w_req   = 1'b0;
      w_abort = 1'b0;
    end
  end

  assign w_complete = w_req & MemAck;
  assign w_stall    = w_req & ~MemAck & ~w_abort;

  assign MemReq   = w_req;
  assign MemWe    = MemWriteM;
  assign MemAddr  = ALUOutM;
  assign MemWData = WriteDataM;
  assign StallM   = w_stall;
  assign MemErr   = r_mem_err;

  // Only the low register-index bits travel down the pipe.
  assign w_unused_wreg = ^WriteRegM[31:REG_IDX_W];

  assign w_wb_d.reg_write  = RegWriteM;
  assign w_wb_d.mem_to_reg = MemtoRegM;
  assign w_wb_d.alu_out    = ALUOutM;
  assign w_wb_d.read_data  = MemRData;
  assign w_wb_d.write_reg  = WriteRegM[REG_IDX_W-1:0];

  mem_wb_reg u_mem_wb_reg (
    .i_clk        (clk),
    .i_reset      (Reset),
    .i_bubble     (w_stall | w_abort),
    .i_load_rdata (w_complete & ~MemWriteM),
    .i_d          (w_wb_d),
    .o_q          (w_wb_q)
  );

  assign RegWriteW = w_wb_q.reg_write;
  assign MemtoRegW = w_wb_q.mem_to_reg;
  assign ALUOutW   = w_wb_q.alu_out;
  assign ReadDataW = w_wb_q.read_data;
  assign WriteRegW = 32'(w_wb_q.write_reg);

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

MEM-stage controller of the pipelined MIPS core: consumes the EX/MEM register outputs, drives a data memory through a request/acknowledge handshake, stalls the pipeline while an access is outstanding, and holds the MEM/WB pipeline register feeding write-back. Sits between the EX/MEM register and the WB-stage result mux and register-file write port.

## Interface
- TIMEOUT, 16: wait cycles without MemAck before an access is aborted (≥1)
- CW, 5: width of the timeout counter; 2^CW > TIMEOUT
- clk  input  1  pipeline clock, rising edge
- Reset  input  1  synchronous, active-high reset
- RegWriteM, MemtoRegM, MemWriteM  input  1 each  control from EX/MEM
- ALUOutM  input  32  address / ALU result from EX/MEM
- WriteDataM  input  32  store data from EX/MEM
- WriteRegM  input  32  destination register from EX/MEM (bits [4:0] significant)
- MemReq  output  1  data-memory request (combinational)
- MemWe  output  1  write enable, valid with MemReq
- MemAddr, MemWData  output  32 each  = ALUOutM, WriteDataM
- MemRData  input  32  read data, valid in the MemAck cycle
- MemAck  input  1  access-complete strobe
- StallM  output  1  freeze PC, IF/ID, ID/EX, EX/MEM (combinational)
- MemErr  output  1  one-cycle pulse on access timeout (registered)
- RegWriteW, MemtoRegW  output  1 each  MEM/WB control
- ALUOutW, ReadDataW, WriteRegW  output  32 each  MEM/WB data

## Operation
- Access = MemtoRegM | MemWriteM. MemWe = MemWriteM (write wins if both set).
- FSM states: IDLE, WAIT.
- IDLE: MemReq = Access. Access & MemAck → complete, stay IDLE. Access & !MemAck → WAIT, counter ← 1.
- WAIT: MemReq = 1, address/data/MemWe held stable by stall. MemAck → complete, IDLE. Else counter = TIMEOUT → abort, IDLE, MemErr ← 1. Else counter++.
- StallM = MemReq & !MemAck & !abort condition.
- MEM/WB load every non-reset edge:
  - complete or non-access instruction: RegWriteW, MemtoRegW, ALUOutW, WriteRegW ← M values; ReadDataW ← MemRData on load completion, else holds.
  - stall cycle or abort: bubble, RegWriteW ← 0, MemtoRegW ← 0; other fields hold.
- Abort drops the instruction (no register write); pipeline resumes next cycle.
- MemAck while MemReq = 0: ignored.
- Reset high: MemReq, StallM forced 0 combinationally.

## Timing
- Reset (synchronous): state IDLE, counter 0, MemErr 0, all W outputs 0.
- Zero-wait access (ack in request cycle): no stall, W valid next edge.
- N-cycle wait: StallM high N cycles; W valid the edge after the ack cycle; N bubbles reach WB.
- Timeout: MemReq high TIMEOUT+1 cycles, MemErr high the following cycle only.
- Reset mid-WAIT: request dropped in the reset cycle; late MemAck after reset ignored.
- Back-to-back accesses: new request may start the cycle after a completion.

## Structure
- Shared package mips_pkg: FSM state encoding, TIMEOUT default, register-index width.
- Sub-module mem_wb_reg: plain MEM/WB register with synchronous Reset and bubble input; FSM, counter and handshake logic stay in mem_access_stage.

## Test plan
- Reset asserted mid-operation → next cycle all W outputs 0, MemErr 0, MemReq 0.
- ALU op (RegWriteM=1, ALUOutM=0x1234, WriteRegM=8), no access → MemReq 0, StallM 0, next cycle RegWriteW=1, ALUOutW=0x1234, WriteRegW=8.
- Load addr 0x40, MemAck same cycle with MemRData=0xDEADBEEF → no stall, next cycle ReadDataW=0xDEADBEEF, MemtoRegW=1.
- Store addr 0x80 data 0x55, MemAck after 3 cycles → StallM high 3 cycles, MemWe=1 throughout, 3 bubbles (RegWriteW=0), address stable.
- Load with no ack, TIMEOUT=4 → MemReq high 5 cycles, MemErr pulses once, RegWriteW stays 0, StallM low afterward.
- Stray MemAck in IDLE with no access → no state change, W follows M normally.
